// File: rtl/ftdi_frame_scheduler_pkg.sv
// Shared types and constants for the FTDI frame scheduler: FSM states, frame
// geometry and the layout of the per-frame ID byte.
package ftdi_frame_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_SYNC = 2'd1,
    HDR_ID   = 2'd2,
    PAYLOAD  = 2'd3
  } state_t;

  localparam int FRAME_BYTES   = 10;
  localparam int PAYLOAD_BYTES = 8;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam int ID_CNT_MSB = 7;
  localparam int ID_CNT_LSB = 4;
  localparam int ID_CH_MSB  = 3;
  localparam int ID_CH_LSB  = 0;

  // Upper nibble carries the low bits of the frame counter, lower nibble the channel.
  function automatic logic [7:0] id_byte(input logic [3:0] cnt, input logic [3:0] ch);
    logic [7:0] b;
    b = '0;
    b[ID_CNT_MSB:ID_CNT_LSB] = cnt;
    b[ID_CH_MSB:ID_CH_LSB]   = ch;
    return b;
  endfunction

endpackage

// File: rtl/ftdi_frame_scheduler_if.sv
// Bundles the per-channel word request handshake and the FTDI byte write port.
interface ftdi_frame_scheduler_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0]    req_valid;
  logic [64*NUM_CH-1:0] req_data;
  logic [NUM_CH-1:0]    req_ack;
  logic                 ftdi_full;
  logic                 ftdi_wr_en;
  logic [7:0]           ftdi_data;

  modport master (
    output req_valid,
    output req_data,
    output ftdi_full,
    input  req_ack,
    input  ftdi_wr_en,
    input  ftdi_data
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  ftdi_full,
    output req_ack,
    output ftdi_wr_en,
    output ftdi_data
  );

endinterface

// File: rtl/ftdi_frame_scheduler_rr_grant.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// scanning cyclically. Reusable for any shared resource.
module rr_grant #(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  grant,
  output logic              grant_valid
);

  int               off;
  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    off         = 0;
    idx         = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      off = int'(ptr) + k;
      if (off >= NUM_CH) off = off - NUM_CH;
      idx = IDX_W'(off);
      if (req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ftdi_frame_scheduler.sv
// Shares the FTDI byte port between NUM_CH word sources: each granted 64-bit
// word goes out as SYNC, ID, then 8 payload bytes MSB first, honouring ftdi_full.
module ftdi_frame_scheduler
  import ftdi_frame_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                   clk_pll,
  input  logic                   rst,
  ftdi_frame_scheduler_if.slave  bus,
  output logic                   busy,
  output logic [15:0]            frame_cnt
);

  localparam int IDX_W = $clog2(NUM_CH);

  state_t            state, state_n;
  logic [IDX_W-1:0]  ptr, ptr_n;
  logic [IDX_W-1:0]  grant, grant_n;
  logic [IDX_W-1:0]  pick;
  logic              pick_valid;
  logic [63:0]       word;
  logic [63:0]       shreg, shreg_n;
  logic [2:0]        byte_cnt, byte_cnt_n;
  logic [15:0]       frame_cnt_n;
  logic [NUM_CH-1:0] ack_n;
  logic              wr_n;
  logic [7:0]        data_n;

  rr_grant #(
    .NUM_CH (NUM_CH)
  ) u_rr_grant (
    .req         (bus.req_valid),
    .ptr         (ptr),
    .grant       (pick),
    .grant_valid (pick_valid)
  );

  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick == IDX_W'(i)) word = bus.req_data[64*i +: 64];
    end
  end

  // Every non-idle state emits one byte per unstalled cycle; a stall freezes all state.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    grant_n     = grant;
    shreg_n     = shreg;
    byte_cnt_n  = byte_cnt;
    frame_cnt_n = frame_cnt;
    ack_n       = '0;
    wr_n        = 1'b0;
    data_n      = bus.ftdi_data;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_n     = pick;
          shreg_n     = word;
          ack_n[pick] = 1'b1;
          state_n     = HDR_SYNC;
        end
      end
      HDR_SYNC: begin
        if (!bus.ftdi_full) begin
          wr_n    = 1'b1;
          data_n  = SYNC_BYTE;
          state_n = HDR_ID;
        end
      end
      HDR_ID: begin
        if (!bus.ftdi_full) begin
          wr_n       = 1'b1;
          data_n     = id_byte(frame_cnt[3:0], 4'(grant));
          byte_cnt_n = '0;
          state_n    = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!bus.ftdi_full) begin
          wr_n       = 1'b1;
          data_n     = shreg[63:56];
          shreg_n    = {shreg[55:0], 8'h00};
          byte_cnt_n = byte_cnt + 3'd1;
          if (byte_cnt == 3'(PAYLOAD_BYTES - 1)) begin
            frame_cnt_n = frame_cnt + 16'd1;
            ptr_n       = (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + IDX_W'(1);
            state_n     = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_pll) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      byte_cnt       <= '0;
      frame_cnt      <= '0;
      bus.req_ack    <= '0;
      bus.ftdi_wr_en <= 1'b0;
      bus.ftdi_data  <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      ptr            <= ptr_n;
      byte_cnt       <= byte_cnt_n;
      frame_cnt      <= frame_cnt_n;
      bus.req_ack    <= ack_n;
      bus.ftdi_wr_en <= wr_n;
      bus.ftdi_data  <= data_n;
      busy           <= (state_n != IDLE);
    end
  end

  // Captured word and grant index are only consumed after being loaded in IDLE.
  always_ff @(posedge clk_pll) begin
    shreg <= shreg_n;
    grant <= grant_n;
  end

endmodule
